key_hold_tracker: RTL and testbench

//  Sits between the NIOS keycode PIO (one 8-bit USB keycode at a time) and the

---
 rtl/key_hold_tracker.sv | 138 +++++++++++++
 tb/tb_key_hold_tracker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/key_hold_tracker.sv
// Converts the single NIOS keycode stream into held per-player move flags using
// per-key hold timers aged by the frame clock, plus a one-shot Enter confirm.
module key_hold_tracker #(
  parameter int HOLD_FRAMES = 4,
  parameter int TW          = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       frame_clk,
  output logic       fireboy_jump,
  output logic       fireboy_left,
  output logic       fireboy_right,
  output logic       icegirl_jump,
  output logic       icegirl_left,
  output logic       icegirl_right,
  output logic       confirm
);

  localparam int NK      = 7;
  localparam int K_W     = 0;
  localparam int K_A     = 1;
  localparam int K_D     = 2;
  localparam int K_UP    = 3;
  localparam int K_LEFT  = 4;
  localparam int K_RIGHT = 5;
  localparam int K_ENTER = 6;
  localparam logic [TW-1:0] RELOAD = TW'(HOLD_FRAMES);

  logic [2:0]    frame_sync;
  logic          frame_tick;
  logic [7:0]    kc_q;
  logic          accept;
  logic [NK-1:0] key_hit;
  logic [TW-1:0] timer [NK];
  logic [NK-1:0] held;
  logic          fb_last_right;
  logic          ig_last_right;
  logic          enter_q;
  logic          fb_left_d, fb_right_d, ig_left_d, ig_right_d;

  // Two sync flops plus one history flop for rising-edge detection.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_sync <= '0;
      kc_q       <= '0;
    end else begin
      frame_sync <= {frame_sync[1:0], frame_clk};
      kc_q       <= keycode;
    end
  end

  assign frame_tick = frame_sync[1] & ~frame_sync[2];
  assign accept     = (keycode == kc_q) && (keycode != 8'h00);

  always_comb begin
    key_hit = '0;
    if (accept) begin
      key_hit[K_W]     = (keycode == 8'h1A);
      key_hit[K_A]     = (keycode == 8'h04);
      key_hit[K_D]     = (keycode == 8'h07);
      key_hit[K_UP]    = (keycode == 8'h52);
      key_hit[K_LEFT]  = (keycode == 8'h50);
      key_hit[K_RIGHT] = (keycode == 8'h4F);
      key_hit[K_ENTER] = (keycode == 8'h28);
    end
  end

  // A fresh sighting beats a simultaneous frame tick.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < NK; k++) timer[k] <= '0;
    end else begin
      for (int k = 0; k < NK; k++) begin
        if (key_hit[k])
          timer[k] <= RELOAD;
        else if (frame_tick && (timer[k] != '0))
          timer[k] <= timer[k] - TW'(1);
      end
    end
  end

  always_comb begin
    held = '0;
    for (int k = 0; k < NK; k++) held[k] = (timer[k] != '0);
  end

  // When both directions are held, the most recently pressed one wins.
  always_comb begin
    fb_left_d  = held[K_A];
    fb_right_d = held[K_D];
    ig_left_d  = held[K_LEFT];
    ig_right_d = held[K_RIGHT];
    if (held[K_A] && held[K_D]) begin
      fb_left_d  = ~fb_last_right;
      fb_right_d = fb_last_right;
    end
    if (held[K_LEFT] && held[K_RIGHT]) begin
      ig_left_d  = ~ig_last_right;
      ig_right_d = ig_last_right;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fb_last_right <= 1'b0;
      ig_last_right <= 1'b0;
    end else begin
      if (key_hit[K_A])     fb_last_right <= 1'b0;
      if (key_hit[K_D])     fb_last_right <= 1'b1;
      if (key_hit[K_LEFT])  ig_last_right <= 1'b0;
      if (key_hit[K_RIGHT]) ig_last_right <= 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fireboy_jump  <= 1'b0;
      fireboy_left  <= 1'b0;
      fireboy_right <= 1'b0;
      icegirl_jump  <= 1'b0;
      icegirl_left  <= 1'b0;
      icegirl_right <= 1'b0;
      enter_q       <= 1'b0;
      confirm       <= 1'b0;
    end else begin
      fireboy_jump  <= held[K_W];
      fireboy_left  <= fb_left_d;
      fireboy_right <= fb_right_d;
      icegirl_jump  <= held[K_UP];
      icegirl_left  <= ig_left_d;
      icegirl_right <= ig_right_d;
      enter_q       <= held[K_ENTER];
      confirm       <= held[K_ENTER] & ~enter_q;
    end
  end

endmodule

// File: tb/tb_key_hold_tracker.sv
// Randomised and directed bench for key_hold_tracker, checked cycle by cycle
// against a per-key "frames remaining" model of the hold behaviour.
module tb_key_hold_tracker;

  localparam int HOLD = 4;
  localparam logic [7:0] KEYS [0:6] = '{8'h1A, 8'h04, 8'h07, 8'h52, 8'h50, 8'h4F, 8'h28};

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] keycode;
  logic       frame_clk;
  logic       fireboy_jump, fireboy_left, fireboy_right;
  logic       icegirl_jump, icegirl_left, icegirl_right;
  logic       confirm;

  key_hold_tracker #(.HOLD_FRAMES(HOLD), .TW(3)) dut (
    .Clk          (clk),
    .Reset        (reset),
    .keycode      (keycode),
    .frame_clk    (frame_clk),
    .fireboy_jump (fireboy_jump),
    .fireboy_left (fireboy_left),
    .fireboy_right(fireboy_right),
    .icegirl_jump (icegirl_jump),
    .icegirl_left (icegirl_left),
    .icegirl_right(icegirl_right),
    .confirm      (confirm)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int fc_half;
  int fc_cnt;
  int confirm_count;

  // Reference model: frames left per key, which direction was pressed last,
  // recent keycode / frame_clk samples and the expected output vector.
  int         remaining [0:6];
  bit         prefer_right [0:1];
  bit         enter_was_held;
  logic [7:0] kc_prev;
  logic [3:0] fc_hist;
  logic [7:0] exp_out;

  function automatic logic [7:0] dut_vec();
    return {1'b0, fireboy_jump, fireboy_left, fireboy_right,
            icegirl_jump, icegirl_left, icegirl_right, confirm};
  endfunction

  function automatic logic [1:0] resolve(input bit l, input bit r, input bit pref_r);
    if (l && r) return pref_r ? 2'b01 : 2'b10;
    return {l, r};
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 7; k++) remaining[k] = 0;
    prefer_right[0] = 1'b0;
    prefer_right[1] = 1'b0;
    enter_was_held  = 1'b0;
    kc_prev         = 8'h00;
    fc_hist         = 4'h0;
    exp_out         = 8'h00;
  endtask

  // One clock edge of the model, using the inputs the DUT sees at that edge.
  task automatic model_step();
    bit         tick, acc;
    bit         h [0:6];
    logic [7:0] nxt;
    tick = fc_hist[1] && !fc_hist[2];
    acc  = (keycode == kc_prev) && (keycode != 8'h00);
    for (int k = 0; k < 7; k++) h[k] = (remaining[k] > 0);
    nxt      = 8'h00;
    nxt[6]   = h[0];
    nxt[5:4] = resolve(h[1], h[2], prefer_right[0]);
    nxt[3]   = h[3];
    nxt[2:1] = resolve(h[4], h[5], prefer_right[1]);
    nxt[0]   = h[6] && !enter_was_held;
    enter_was_held = h[6];
    exp_out = nxt;
    for (int k = 0; k < 7; k++) begin
      if (acc && keycode == KEYS[k]) remaining[k] = HOLD;
      else if (tick && remaining[k] > 0) remaining[k] = remaining[k] - 1;
    end
    if (acc && keycode == 8'h04) prefer_right[0] = 1'b0;
    if (acc && keycode == 8'h07) prefer_right[0] = 1'b1;
    if (acc && keycode == 8'h50) prefer_right[1] = 1'b0;
    if (acc && keycode == 8'h4F) prefer_right[1] = 1'b1;
    kc_prev = keycode;
    fc_hist = {fc_hist[2:0], frame_clk};
  endtask

  task automatic advance_frame();
    fc_cnt++;
    if (fc_cnt >= fc_half) begin
      frame_clk = ~frame_clk;
      fc_cnt = 0;
    end
  endtask

  // Entered and left on a negedge; holds one keycode for the given cycles.
  task automatic applyStimulus(input logic [7:0] kc, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      keycode = kc;
      @(posedge clk);
      model_step();
      @(negedge clk);
      checkOutput("cycle", dut_vec(), exp_out);
      if (confirm === 1'b1) confirm_count++;
      advance_frame();
    end
  endtask

  initial begin
    logic [7:0] pool [0:9];
    reset = 1'b1;
    keycode = 8'h00;
    frame_clk = 1'b0;
    fc_half = 5;
    fc_cnt = 0;
    confirm_count = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state", dut_vec(), 8'h00);
    reset = 1'b0;

    // 1: short W press, then release and expiry
    applyStimulus(8'h1A, 2);
    applyStimulus(8'h00, 1);
    checkOutput("t1_jump_on", {7'b0, fireboy_jump}, 8'h01);
    applyStimulus(8'h00, 60);
    checkOutput("t1_expired", dut_vec(), 8'h00);

    // 2: players alternating keys keep both jumps up
    for (int s = 0; s < 8; s++) applyStimulus(s[0] ? 8'h52 : 8'h1A, 10);
    checkOutput("t2_both_jump", {6'b0, fireboy_jump, icegirl_jump}, 8'h03);
    applyStimulus(8'h00, 60);

    // 3: direction conflict, most recent wins
    applyStimulus(8'h04, 6);
    applyStimulus(8'h07, 6);
    checkOutput("t3_right_wins", {6'b0, fireboy_left, fireboy_right}, 8'h01);
    applyStimulus(8'h00, 60);
    applyStimulus(8'h04, 4);
    applyStimulus(8'h00, 2);
    checkOutput("t3_left_again", {6'b0, fireboy_left, fireboy_right}, 8'h02);
    applyStimulus(8'h00, 60);

    // 4: long Enter press gives a single confirm pulse
    fc_half = 15;
    confirm_count = 0;
    applyStimulus(8'h28, 100);
    applyStimulus(8'h00, 150);
    checkOutput("t4_confirm_pulses", 8'(confirm_count), 8'h01);
    fc_half = 5;

    // 5: single-cycle keycodes are rejected
    applyStimulus(8'h99, 1);
    applyStimulus(8'h00, 2);
    applyStimulus(8'h1A, 1);
    applyStimulus(8'h00, 6);
    checkOutput("t5_glitch", dut_vec(), 8'h00);

    // 6: asynchronous reset in the middle of a hold
    applyStimulus(8'h1A, 4);
    applyStimulus(8'h28, 4);
    checkOutput("t6_held", {7'b0, fireboy_jump}, 8'h01);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 checkOutput("t6_async_clear", dut_vec(), 8'h00);
    model_reset();
    keycode = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    confirm_count = 0;
    applyStimulus(8'h00, 20);
    checkOutput("t6_stay_low", dut_vec(), 8'h00);
    checkOutput("t6_no_confirm", 8'(confirm_count), 8'h00);

    // Random mix of tracked, unmapped and idle keycodes with varying frame rates
    for (int k = 0; k < 7; k++) pool[k] = KEYS[k];
    pool[7] = 8'h00;
    pool[8] = 8'h99;
    pool[9] = 8'h1B;
    for (int s = 0; s < 250; s++) begin
      fc_half = $urandom_range(2, 8);
      applyStimulus(pool[$urandom_range(0, 9)], $urandom_range(1, 14));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
